// File: rtl/led_breath.sv
// LED breathing controller: PWM driver whose duty ramps up, holds, ramps down, holds, repeatedly.
// The PWM counter only moves on the upstream tick strobe; all duty/phase changes happen on counter wrap.
module led_breath #(
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned HOLD_PERIODS = 4
) (
    input  logic                m_clock,
    input  logic                p_reset,
    input  logic                enable,
    input  logic                tick,
    output logic                led,
    output logic [PWM_BITS-1:0] duty,
    output logic [2:0]          phase,
    output logic                period_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam logic [PWM_BITS-1:0] ALL_ONES  = '1;
    localparam logic [7:0]          HOLD_LAST = 8'(HOLD_PERIODS - 1);

    state_t              state, state_n;
    logic [PWM_BITS-1:0] pwm_cnt, cnt_n;
    logic [PWM_BITS-1:0] duty_n;
    logic [7:0]          hold_cnt, hold_n;
    logic                led_n, pd_n, wrap;

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state       <= IDLE;
            pwm_cnt     <= '0;
            duty        <= '0;
            hold_cnt    <= '0;
            led         <= 1'b0;
            period_done <= 1'b0;
        end else begin
            state       <= state_n;
            pwm_cnt     <= cnt_n;
            duty        <= duty_n;
            hold_cnt    <= hold_n;
            led         <= led_n;
            period_done <= pd_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = pwm_cnt;
        duty_n  = duty;
        hold_n  = hold_cnt;
        pd_n    = 1'b0;
        wrap    = tick && (pwm_cnt == ALL_ONES);

        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            duty_n  = '0;
            hold_n  = '0;
        end else if (state == IDLE) begin
            // Start-up cycle: any tick arriving now is deliberately dropped.
            state_n = RISE;
            cnt_n   = '0;
            duty_n  = '0;
            hold_n  = '0;
        end else begin
            if (tick) begin
                cnt_n = pwm_cnt + PWM_BITS'(1);
            end
            pd_n = wrap;
            if (wrap) begin
                case (state)
                    RISE: begin
                        duty_n = (duty == ALL_ONES) ? duty : duty + PWM_BITS'(1);
                        if (duty_n == ALL_ONES) begin
                            state_n = HOLD_HI;
                            hold_n  = '0;
                        end
                    end
                    HOLD_HI: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_n = FALL;
                            hold_n  = '0;
                        end else begin
                            hold_n = hold_cnt + 8'd1;
                        end
                    end
                    FALL: begin
                        duty_n = (duty == '0) ? duty : duty - PWM_BITS'(1);
                        if (duty_n == '0) begin
                            state_n = HOLD_LO;
                            hold_n  = '0;
                        end
                    end
                    HOLD_LO: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_n = RISE;
                            hold_n  = '0;
                        end else begin
                            hold_n = hold_cnt + 8'd1;
                        end
                    end
                    default: begin
                        state_n = IDLE;
                    end
                endcase
            end
        end

        // LED compares the post-update counter against the post-update duty.
        led_n = (state_n != IDLE) && (cnt_n < duty_n);
    end

    assign phase = state;

endmodule

// File: doc/led_breath.md
LED_BREATH -- requirements
Module: led_breath

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, width of the PWM counter and duty register.
REQ-002 SHALL have parameter HOLD_PERIODS, default 4, number of full PWM periods spent at each extreme (1..255).
REQ-003 SHALL have port m_clock, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port p_reset, input, 1, synchronous active-high reset, sampled on rising m_clock.
REQ-005 SHALL have port enable, input, 1, level; 1 = run breathing sequence, 0 = force idle.
REQ-006 SHALL have port tick, input, 1, one-cycle strobe from the upstream free-running counter stage; advances PWM by one step.
REQ-007 SHALL have port led, output, 1, PWM-modulated LED drive.
REQ-008 SHALL have port duty, output, PWM_BITS, current duty value.
REQ-009 SHALL have port phase, output, 3, state encoding: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4.
REQ-010 SHALL have port period_done, output, 1, one-cycle pulse when pwm_cnt wraps from max to 0.

Function
REQ-011 SHALL keep internal pwm_cnt (PWM_BITS); on tick with state != IDLE: increment, wrapping all-ones -> 0; else hold.
REQ-012 SHALL assert period_done registered, in the cycle after a tick that wraps pwm_cnt all-ones -> 0, and only when state != IDLE.
REQ-013 SHALL drive led registered: led <= (state != IDLE) && (pwm_cnt < duty), evaluated on the updated pwm_cnt; one cycle latency from tick.
REQ-014 SHALL, in IDLE with enable=1, go to RISE next cycle with duty=0, pwm_cnt=0; a tick in that same cycle is ignored.
REQ-015 SHALL, in RISE, on each wrap increment duty by 1; when duty reaches all-ones go to HOLD_HI in the same update.
REQ-016 SHALL, in HOLD_HI, count HOLD_PERIODS wraps then go to FALL; hold counter cleared on entry.
REQ-017 SHALL, in FALL, on each wrap decrement duty by 1; when duty reaches 0 go to HOLD_LO in the same update.
REQ-018 SHALL, in HOLD_LO, count HOLD_PERIODS wraps then go to RISE; sequence repeats indefinitely.
REQ-019 SHALL saturate duty: never increment past all-ones nor decrement below 0.
REQ-020 SHALL, on enable=0 in any state, go to IDLE next cycle, clearing duty, pwm_cnt, hold counter; led=0 and period_done=0 from that cycle; tick that cycle ignored.
REQ-021 SHALL give enable=0 priority over any simultaneous tick/wrap transition.
REQ-022 SHALL never light led when duty=0; with duty=all-ones led is low only for pwm_cnt=all-ones.

Reset
REQ-023 SHALL, when p_reset=1 at a rising edge, set state=IDLE, pwm_cnt=0, duty=0, hold counter=0, led=0, period_done=0, phase=0.
REQ-024 SHALL give p_reset priority over enable and tick; reset mid-sequence aborts it with no residual state.
REQ-025 SHALL restart from RISE, duty=0, on first enable=1 cycle after reset release.

Verification
REQ-026 Reset then enable=1, tick every cycle -> phase=1 one cycle later; period_done first pulses 256 ticks later; duty=1 after it.
REQ-027 Force duty=3 point (RISE, after 3 wraps), tick every cycle -> led high for pwm_cnt 0,1,2 and low for 3..255 each period.
REQ-028 Run full ramp, HOLD_PERIODS=4 -> duty=255 and phase=2 after 255 wraps; phase=3 after 4 more wraps; duty reaches 0, phase=4 after 255 more.
REQ-029 Tick every 3rd cycle -> pwm_cnt advances only on ticks; period length 768 cycles; led never changes between ticks.
REQ-030 enable=0 mid-FALL with duty=100 and simultaneous wrap tick -> next cycle phase=0, duty=0, led=0, period_done=0.
REQ-031 p_reset=1 mid-HOLD_HI with enable=1 held -> phase=0, duty=0 during reset; phase=1 one cycle after release, duty=0.
